clkdiv_monitor: RTL and testbench

CLKDIV_MONITOR -- requirements
Module: clkdiv_monitor

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_edge_sync.sv | 35 +++
 rtl/clkdiv_monitor.sv | 176 +++++++++++++++++
 tb/tb_clkdiv_monitor.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the divided-clock monitor: default geometry and FSM states.
package clkdiv_pkg;

  // Expected divided-clock period, lock threshold and counter width defaults
  localparam int DIV_DEF        = 5;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int CNT_W_DEF      = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } mon_state_t;

endpackage

// File: rtl/clkdiv_edge_sync.sv
// Two-flop synchronizer for the divided clock plus a history flop for edge detection.
// The divided clock is only ever sampled as data on clk.
module clkdiv_edge_sync
  import clkdiv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Stage p0/p1 resolve metastability, stage p2 remembers the previous synced level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= d_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;
  assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/clkdiv_monitor.sv
// Divided-clock monitor: measures period and sampled high time of clkdiv_in,
// confirms lock after LOCK_COUNT consecutive good periods and raises a sticky
// fault if the divided clock misbehaves once locked.
module clkdiv_monitor
  import clkdiv_pkg::*;
#(
  parameter int DIV        = DIV_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clkdiv_in,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             locked,
  output logic             fault
);

  localparam int               GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(2 * DIV);
  localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'((DIV + 1) / 2);
  localparam logic [GOOD_W-1:0] LOCK_C = GOOD_W'(LOCK_COUNT);

  // Saturating increment shared by the period and high-time counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic sync_level;
  logic sync_rise;
  logic sync_fall;

  logic rise_p3;
  logic fall_p3;
  logic level_p3;

  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic              tmo_arm;
  logic              tmo_hit;
  logic              per_good;
  logic              hi_good;
  logic [GOOD_W-1:0] good_cnt;
  mon_state_t        state;

  clkdiv_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (clkdiv_in),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  // Stage p3: register edge events so every output is driven from a flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_p3  <= 1'b0;
      fall_p3  <= 1'b0;
      level_p3 <= 1'b0;
    end else begin
      rise_p3  <= sync_rise;
      fall_p3  <= sync_fall;
      level_p3 <= sync_level;
    end
  end

  assign rise_pulse = rise_p3;

  // A rise and a timeout in the same cycle count as the rise only
  assign tmo_hit  = tmo_arm && !rise_p3 && (per_cnt == TMO_C);
  assign per_good = (per_cnt == DIV_C);
  assign hi_good  = (hi_cnt >= HI_MIN) && (hi_cnt <= HI_MAX);

  // Period/high-time measurement; timeout fires once per missing edge via tmo_arm
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      tmo_arm    <= 1'b0;
    end else begin
      if (rise_p3) begin
        period_cnt <= per_cnt;
        per_cnt    <= CNT_W'(1);
        tmo_arm    <= 1'b1;
      end else begin
        per_cnt <= sat_inc(per_cnt);
        if (tmo_hit) begin
          tmo_arm <= 1'b0;
        end
      end

      if (rise_p3) begin
        hi_cnt <= CNT_W'(1);
      end else if (level_p3) begin
        hi_cnt <= sat_inc(hi_cnt);
      end

      if (fall_p3) begin
        high_cnt <= hi_cnt;
      end
    end
  end

  // Lock FSM with registered locked/fault; enable low overrides every transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      good_cnt <= '0;
      locked   <= 1'b0;
      fault    <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      good_cnt <= '0;
      locked   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          good_cnt <= '0;
          state    <= ACQUIRE;
        end
        ACQUIRE: begin
          // The period ending at the first edge started before we were looking
          good_cnt <= '0;
          if (rise_p3) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_p3) begin
            if (per_good) begin
              if (good_cnt == LOCK_C - GOOD_W'(1)) begin
                good_cnt <= LOCK_C;
                state    <= LOCKED;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (tmo_hit) begin
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if ((rise_p3 && !per_good) || (fall_p3 && !hi_good) || tmo_hit) begin
            state  <= FAULT;
            locked <= 1'b0;
            fault  <= 1'b1;
          end
        end
        FAULT: begin
          locked <= 1'b0;
          fault  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          good_cnt <= '0;
          locked   <= 1'b0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Directed bench for clkdiv_monitor (DIV=5, LOCK_COUNT=4, CNT_W=4).
// clkdiv_in changes on falling clk edges; outputs are sampled on falling edges.
`timescale 1ns/1ps
module tb_clkdiv_monitor;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             clkdiv_in;
  logic             rise_pulse;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             locked;
  logic             fault;

  int n_cmp  = 0;
  int n_bad  = 0;
  int rise_n = 0;
  int rn;

  clkdiv_monitor #(
    .DIV        (5),
    .LOCK_COUNT (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clkdiv_in  (clkdiv_in),
    .rise_pulse (rise_pulse),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .locked     (locked),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Count rise pulses as seen on falling edges
  always @(negedge clk) begin
    if (rise_pulse === 1'b1) rise_n++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_cyc(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      clkdiv_in = v;
      @(negedge clk);
    end
  endtask

  task automatic play(input int p, input int h);
    drive_cyc(1'b1, h);
    drive_cyc(1'b0, p - h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b0; clkdiv_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rise",   32'(rise_pulse), 0);
    check_eq("rst_period", 32'(period_cnt), 0);
    check_eq("rst_high",   32'(high_cnt),   0);
    check_eq("rst_locked", 32'(locked),     0);
    check_eq("rst_fault",  32'(fault),      0);
    reset = 1'b1;
    @(negedge clk);

    // Steady divide-by-5 with 2/3 duty variation: lock after the 5th edge
    enable = 1'b1;
    rn = rise_n;
    play(5, 2); play(5, 3); play(5, 2); play(5, 3);
    check_eq("acq_not_locked", 32'(locked), 0);
    play(5, 2);
    check_eq("acq_locked",  32'(locked),     1);
    check_eq("acq_fault",   32'(fault),      0);
    check_eq("acq_period",  32'(period_cnt), 5);
    check_eq("acq_high3",   32'(high_cnt),   3);
    check_eq("acq_rises",   32'(rise_n - rn), 5);
    // rise_pulse latency 3 and single-cycle width
    drive_cyc(1'b1, 2);
    check_eq("rise_lat2", 32'(rise_pulse), 0);
    drive_cyc(1'b0, 1);
    check_eq("rise_lat3", 32'(rise_pulse), 1);
    drive_cyc(1'b0, 1);
    check_eq("rise_lat4", 32'(rise_pulse), 0);
    check_eq("acq_high2", 32'(high_cnt),   2);
    drive_cyc(1'b0, 1);

    // Timeout: clkdiv stuck low, fault when counter reaches 10
    play(5, 2);
    drive_cyc(1'b0, 8);
    check_eq("tmo_pre_fault",  32'(fault),  0);
    check_eq("tmo_pre_locked", 32'(locked), 1);
    drive_cyc(1'b0, 1);
    check_eq("tmo_fault",  32'(fault),  1);
    check_eq("tmo_locked", 32'(locked), 0);
    drive_cyc(1'b0, 3);
    play(5, 2);
    check_eq("tmo_sat_period", 32'(period_cnt), 15);
    check_eq("tmo_sticky0",    32'(fault),      1);
    for (int i = 0; i < 3; i++) begin
      play(5, 2);
      check_eq("tmo_sticky",    32'(fault),  1);
      check_eq("tmo_no_locked", 32'(locked), 0);
    end
    check_eq("tmo_period_back", 32'(period_cnt), 5);

    // Enable toggle clears fault, then relock; then a 6-cycle period
    enable = 1'b0;
    play(5, 2);
    check_eq("dis_fault",  32'(fault),  0);
    check_eq("dis_locked", 32'(locked), 0);
    enable = 1'b1;
    repeat (5) play(5, 2);
    check_eq("relock1", 32'(locked), 1);
    play(6, 3);
    drive_cyc(1'b1, 2);
    drive_cyc(1'b0, 1);
    check_eq("p6_rise",         32'(rise_pulse), 1);
    check_eq("p6_still_locked", 32'(locked),     1);
    check_eq("p6_no_fault_yet", 32'(fault),      0);
    drive_cyc(1'b0, 1);
    check_eq("p6_fault",  32'(fault),      1);
    check_eq("p6_locked", 32'(locked),     0);
    check_eq("p6_period", 32'(period_cnt), 6);
    drive_cyc(1'b0, 1);
    enable = 1'b0;
    play(5, 2);
    check_eq("p6_clear", 32'(fault), 0);
    enable = 1'b1;
    repeat (4) play(5, 2);
    check_eq("relock2_early", 32'(locked), 0);
    play(5, 2);
    check_eq("relock2", 32'(locked), 1);

    // MEASURE sequence 5,5,4,5,5,5,5: the 4 restarts the good count
    enable = 1'b0;
    play(5, 2);
    enable = 1'b1;
    play(5, 2); play(5, 2); play(4, 2); play(5, 2);
    check_eq("seq_period4", 32'(period_cnt), 4);
    check_eq("seq_lock_a",  32'(locked),     0);
    play(5, 2);
    check_eq("seq_lock_b", 32'(locked), 0);
    play(5, 2);
    check_eq("seq_lock_c", 32'(locked), 0);
    play(5, 2);
    check_eq("seq_lock_d", 32'(locked), 0);
    play(5, 2);
    check_eq("seq_locked", 32'(locked), 1);

    // Asynchronous reset mid-period while locked, released with clkdiv high
    play(5, 2);
    check_eq("ar_pre_locked", 32'(locked), 1);
    drive_cyc(1'b1, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_rise",   32'(rise_pulse), 0);
    check_eq("ar_period", 32'(period_cnt), 0);
    check_eq("ar_high",   32'(high_cnt),   0);
    check_eq("ar_locked", 32'(locked),     0);
    check_eq("ar_fault",  32'(fault),      0);
    @(negedge clk);
    reset = 1'b1;
    rn = rise_n;
    drive_cyc(1'b1, 1);
    drive_cyc(1'b0, 2);
    repeat (4) play(5, 2);
    check_eq("ar_rises5",     32'(rise_n - rn), 5);
    check_eq("ar_not_locked", 32'(locked),      0);
    play(5, 2);
    check_eq("ar_rises6", 32'(rise_n - rn), 6);
    check_eq("ar_relock", 32'(locked),      1);

    // Single-cycle glitch while locked
    rn = rise_n;
    drive_cyc(1'b1, 1);
    drive_cyc(1'b0, 11);
    check_eq("gl_rises",  32'(rise_n - rn), 1);
    check_eq("gl_high",   32'(high_cnt),    1);
    check_eq("gl_fault",  32'(fault),       1);
    check_eq("gl_locked", 32'(locked),      0);
    check_eq("gl_no_x",   32'($isunknown({rise_pulse, period_cnt, high_cnt, locked, fault})), 0);
    play(5, 2);
    check_eq("gl_period", 32'(period_cnt), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
